// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response path: data-phase select register, per-slave
// response steering and the built-in default slave (two-cycle ERROR).

module ahb_resp_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] slv_data,
    input  logic                  slv_rdy,
    input  logic                  slv_resp,
    output logic [DATA_WIDTH-1:0] lane_data,
    output logic                  lane_rdy,
    output logic                  lane_resp
);

    // AND-gate by the one-hot select; the top OR-reduces all lanes.
    assign lane_data = {DATA_WIDTH{sel}} & slv_data;
    assign lane_rdy  = sel & slv_rdy;
    assign lane_resp = sel & slv_resp;

endmodule

module ahb_resp_mux #(
    parameter int SLAVE_NUM  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ERRCNT_W   = 8
) (
    input  logic                            hclk,
    input  logic                            hreset,
    input  logic [SLAVE_NUM-1:0]            hsel_in,
    input  logic                            default_slv_sel,
    input  logic [1:0]                      htrans,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] slv_hrdata,
    input  logic [SLAVE_NUM-1:0]            slv_hreadyout,
    input  logic [SLAVE_NUM-1:0]            slv_hresp,
    output logic [DATA_WIDTH-1:0]           hrdata,
    output logic                            hready,
    output logic                            hresp,
    output logic [SLAVE_NUM-1:0]            data_sel,
    output logic [ERRCNT_W-1:0]             err_cnt
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t ds_state;

    logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0] slv_data_a;
    logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0] lane_data;
    logic [SLAVE_NUM-1:0]                 lane_rdy;
    logic [SLAVE_NUM-1:0]                 lane_resp;
    logic [DATA_WIDTH-1:0]                mux_data;
    logic                                 mux_rdy;
    logic                                 mux_resp;
    logic                                 sel_onehot;
    logic                                 sel_legal;
    logic                                 unused_htrans0;

    assign slv_data_a     = slv_hrdata;
    assign unused_htrans0 = htrans[0];

    assign sel_onehot = (hsel_in != '0) &&
                        ((hsel_in & (hsel_in - SLAVE_NUM'(1))) == '0);
    assign sel_legal  = sel_onehot && !default_slv_sel;

    for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_lane
        ahb_resp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .sel       (data_sel[i]),
            .slv_data  (slv_data_a[i]),
            .slv_rdy   (slv_hreadyout[i]),
            .slv_resp  (slv_hresp[i]),
            .lane_data (lane_data[i]),
            .lane_rdy  (lane_rdy[i]),
            .lane_resp (lane_resp[i])
        );
    end

    always_comb begin
        mux_data = '0;
        mux_rdy  = 1'b0;
        mux_resp = 1'b0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            mux_data = mux_data | lane_data[i];
            mux_rdy  = mux_rdy  | lane_rdy[i];
            mux_resp = mux_resp | lane_resp[i];
        end
    end

    // Default slave owns the bus in ERR1/ERR2; data_sel is always 0 there.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            DS_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
            default: begin
                if (data_sel != '0) begin
                    hrdata = mux_data;
                    hready = mux_rdy;
                    hresp  = mux_resp;
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            data_sel <= '0;
            ds_state <= DS_IDLE;
            err_cnt  <= '0;
        end else begin
            case (ds_state)
                DS_ERR1: ds_state <= DS_ERR2;
                default: begin
                    // IDLE and ERR2 both accept a new address when hready is high.
                    if (hready) begin
                        if (htrans[1]) begin
                            if (sel_legal) begin
                                data_sel <= hsel_in;
                                ds_state <= DS_IDLE;
                            end else begin
                                data_sel <= '0;
                                ds_state <= DS_ERR1;
                                if (err_cnt != '1)
                                    err_cnt <= err_cnt + ERRCNT_W'(1);
                            end
                        end else begin
                            data_sel <= '0;
                            ds_state <= DS_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
